// File: rtl/status_unit.sv
// Writeback status register for bex/setx: maps retiring-instruction overflow to an
// exception code, holds it in the status register and logs codes in a small FIFO.
module status_unit #(
    parameter int unsigned TARGET_W = 27,
    parameter int unsigned STATUS_W = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STICKY   = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [4:0]                  opcode,
    input  logic [4:0]                  alu_code,
    input  logic                        overflow,
    input  logic [TARGET_W-1:0]         target,
    input  logic                        clear,
    output logic [STATUS_W-1:0]         status,
    output logic                        status_nz,
    output logic                        exc_pulse,
    output logic                        log_valid,
    output logic [2:0]                  log_data,
    input  logic                        log_pop,
    output logic [$clog2(DEPTH+1)-1:0]  log_count,
    output logic                        log_drop
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [STATUS_W-1:0] status_q, status_d;
    logic                exc_pulse_q, exc_pulse_d;
    logic                log_drop_q, log_drop_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [2:0]          mem_q [DEPTH];
    logic [2:0]          mem_d [DEPTH];

    logic [2:0] code;
    logic       is_setx;
    logic       is_exc;
    logic       full;
    logic       pop_ok;
    logic       do_push;
    logic       drop;
    logic       exc_write_ok;

    always_comb begin
        code = 3'd0;
        if (in_valid && overflow) begin
            if (opcode == 5'b00101) begin
                code = 3'd2;
            end else if (opcode == 5'b00000) begin
                case (alu_code)
                    5'd0:    code = 3'd1;
                    5'd1:    code = 3'd3;
                    5'd6:    code = 3'd4;
                    5'd7:    code = 3'd5;
                    default: code = 3'd0;
                endcase
            end
        end
    end

    assign is_setx = in_valid && (opcode == 5'b10101);
    assign is_exc  = (code != 3'd0);
    // A same-cycle clear empties status first, so a sticky exception may still land.
    assign exc_write_ok = (STICKY == 0) || (status_q == '0) || clear;

    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = log_pop && (count_q != '0);
    assign do_push = is_exc && (!full || pop_ok);
    assign drop    = is_exc && full && !pop_ok;

    always_comb begin
        status_d    = status_q;
        exc_pulse_d = is_exc;
        log_drop_d  = log_drop_q;
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_d       = mem_q;

        if (is_setx) begin
            status_d = STATUS_W'(target);
        end else if (is_exc && exc_write_ok) begin
            status_d = STATUS_W'(code);
        end else if (clear) begin
            status_d = '0;
        end

        if (clear) begin
            log_drop_d = 1'b0;
        end else if (drop) begin
            log_drop_d = 1'b1;
        end

        if (do_push) begin
            mem_d[wptr_q] = code;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q    <= '0;
            exc_pulse_q <= 1'b0;
            log_drop_q  <= 1'b0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            status_q    <= status_d;
            exc_pulse_q <= exc_pulse_d;
            log_drop_q  <= log_drop_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
        end
    end

    assign status    = status_q;
    assign status_nz = (status_q != '0);
    assign exc_pulse = exc_pulse_q;
    assign log_valid = (count_q != '0);
    assign log_data  = mem_q[rptr_q];
    assign log_count = count_q;
    assign log_drop  = log_drop_q;

endmodule
